// File: rtl/prco_uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver with a one-entry valid/ack output buffer; PRCO_UART_RX_PARITY_EN adds an even-parity bit.
// Latency: q_valid rises 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2 cycles after the start edge (+CLKS_PER_BIT with parity).
// Backpressure: none on the line; a byte that completes while q_valid is held without i_ack is dropped and q_overrun pulses.
module prco_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    input  logic       i_ack,
    output logic [7:0] q_data,
    output logic       q_valid,
    output logic       q_busy,
    output logic       q_frame_err,
    output logic       q_overrun
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef PRCO_UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    logic par_err;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            idx         <= 3'd0;
            shift       <= 8'h00;
            q_data      <= 8'h00;
            q_valid     <= 1'b0;
            q_busy      <= 1'b0;
            q_frame_err <= 1'b0;
            q_overrun   <= 1'b0;
`ifdef PRCO_UART_RX_PARITY_EN
            par_err     <= 1'b0;
`endif
        end else begin
            rx_m        <= i_rx;
            rx_s        <= rx_m;
            q_frame_err <= 1'b0;
            q_overrun   <= 1'b0;
            // A completing good byte below overrides this consume.
            if (i_ack) begin
                q_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        q_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        idx <= 3'd0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            q_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
`ifdef PRCO_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef PRCO_UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        par_err <= (^shift) ^ rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            q_frame_err <= 1'b1;
                            state       <= BREAK;
                        end
`ifdef PRCO_UART_RX_PARITY_EN
                        else if (par_err) begin
                            q_frame_err <= 1'b1;
                            state       <= IDLE;
                            q_busy      <= 1'b0;
                        end
`endif
                        else begin
                            // Leave half a bit early so a back-to-back start edge is not missed.
                            state  <= IDLE;
                            q_busy <= 1'b0;
                            if (!q_valid || i_ack) begin
                                q_data  <= shift;
                                q_valid <= 1'b1;
                            end else begin
                                q_overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        q_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    q_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
